// File: rtl/ccff_bitstream_loader_if.sv
// ---------------------------------------------------------------------------
// ccff_bitstream_loader_if
//
// Byte-stream handshake between the chip-level pin/byte front end and the
// configuration-chain loader. A byte moves on any rising clk edge where
// byte_valid and byte_ready are both high.
//
// Signals:
//   byte_data   8  configuration byte, bit 7 is shifted into the chain first
//   byte_valid  1  byte_data holds a byte to be transferred
//   byte_ready  1  loader can take a byte this cycle
//
// Modports:
//   master  byte source (drives byte_data/byte_valid, observes byte_ready)
//   slave   the loader (observes byte_data/byte_valid, drives byte_ready)
// ---------------------------------------------------------------------------
interface ccff_bitstream_loader_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// ccff_bitstream_loader
//
// Writer end of the fabric configuration chain. Bytes arriving on the byte
// interface are serialized MSB-first onto ccff_head, one bit per generated
// prog_clk pulse, for exactly CHAIN_LEN pulses per load. Before any bit is
// shifted, cfg_set is strobed for four clk cycles so the fabric clears its
// configuration. The bit sitting at the far end of the chain (ccff_tail) is
// sampled just before every prog_clk rising edge and folded into a
// CRC-16/CCITT (poly 0x1021, init 0xFFFF) so the previous chain contents
// can be verified after the load.
//
// Parameters:
//   CHAIN_LEN  chain length in bits (>= 1)
//   DIV        clk cycles per prog_clk half period (>= 1)
//   CNT_W      bit-counter width, derived from CHAIN_LEN
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse, begins a load from IDLE or DONE
//   abort      level, ends a load in progress and returns to IDLE
//   byte_if    byte stream (slave side): byte_data, byte_valid, byte_ready
//   ccff_tail  chain output from the fabric
//   prog_clk   generated chain clock (registered)
//   ccff_head  chain input to the fabric (registered)
//   cfg_set    fabric configuration-clear strobe
//   busy       high in CLEAR, WAIT_BYTE, SHIFT_LO, SHIFT_HI
//   done       high in DONE
//   aborted    sticky abort flag, cleared by the next start
//   tail_crc   running CRC of the bits read back from ccff_tail
// ---------------------------------------------------------------------------
module ccff_bitstream_loader #(
    parameter  int CHAIN_LEN = 2048,
    parameter  int DIV       = 2,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    ccff_bitstream_loader_if.slave  byte_if,
    input  logic                    ccff_tail,
    output logic                    prog_clk,
    output logic                    ccff_head,
    output logic                    cfg_set,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [15:0]             tail_crc
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CLEAR     = 3'd1;
    localparam logic [2:0] ST_WAIT_BYTE = 3'd2;
    localparam logic [2:0] ST_SHIFT_LO  = 3'd3;
    localparam logic [2:0] ST_SHIFT_HI  = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    // The same phase counter times both the 4-cycle clear strobe and the
    // DIV-cycle prog_clk half periods, so it is sized for the larger one.
    localparam int PH_MAX = (DIV > 4) ? DIV : 4;
    localparam int PH_W   = $clog2(PH_MAX) + 1;

    localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(DIV - 1);
    localparam logic [PH_W-1:0]  CLEAR_LAST = PH_W'(3);
    localparam logic [PH_W-1:0]  PH_ONE     = PH_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'h1021;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [2:0]       state;
    logic [PH_W-1:0]  phase_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [3:0]       bits_in_byte;
    logic [7:0]       shift_reg;
    logic             byte_ready_q;

    logic             in_load;
    logic             phase_end;
    logic             last_chain_bit;
    logic             last_byte_bit;

    assign byte_if.byte_ready = byte_ready_q;

    // One step of the MSB-first CRC-16/CCITT for a single serial bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic        bit_in);
        logic feedback;
        feedback = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (feedback ? CRC_POLY : 16'h0000);
    endfunction

    assign in_load        = (state != ST_IDLE) && (state != ST_DONE);
    assign phase_end      = (phase_cnt == HALF_LAST);
    assign last_chain_bit = (bit_cnt == CNT_ONE);
    assign last_byte_bit  = (bits_in_byte == 4'd1);

    // -----------------------------------------------------------------------
    // Control FSM and datapath. All outputs are registered and updated on the
    // same edge as the state, so each output always matches the state the
    // loader is in. ccff_head only changes on the edge that drops prog_clk
    // (or while prog_clk is already low), which gives the fabric DIV cycles
    // of setup before and DIV cycles of hold after every rising edge.
    // When the chain ends partway through a byte, the remaining low-order
    // bits of that byte are simply never shifted.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            phase_cnt    <= '0;
            bit_cnt      <= CNT_FULL;
            bits_in_byte <= '0;
            shift_reg    <= '0;
            byte_ready_q <= 1'b0;
            prog_clk     <= 1'b0;
            ccff_head    <= 1'b0;
            cfg_set      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            tail_crc     <= CRC_INIT;
        end else if (abort && in_load) begin
            // Abort wins over any handshake or phase step this cycle; the
            // CRC is left as-is so the partial readback can be inspected.
            state        <= ST_IDLE;
            phase_cnt    <= '0;
            byte_ready_q <= 1'b0;
            prog_clk     <= 1'b0;
            cfg_set      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // abort also suppresses a start presented in the same cycle
                    if (start && !abort) begin
                        state     <= ST_CLEAR;
                        phase_cnt <= '0;
                        bit_cnt   <= CNT_FULL;
                        tail_crc  <= CRC_INIT;
                        aborted   <= 1'b0;
                        cfg_set   <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        prog_clk  <= 1'b0;
                    end
                end

                ST_CLEAR: begin
                    if (phase_cnt == CLEAR_LAST) begin
                        state        <= ST_WAIT_BYTE;
                        phase_cnt    <= '0;
                        cfg_set      <= 1'b0;
                        byte_ready_q <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + PH_ONE;
                    end
                end

                ST_WAIT_BYTE: begin
                    if (byte_if.byte_valid && byte_ready_q) begin
                        state        <= ST_SHIFT_LO;
                        phase_cnt    <= '0;
                        shift_reg    <= byte_if.byte_data;
                        bits_in_byte <= 4'd8;
                        ccff_head    <= byte_if.byte_data[7];
                        byte_ready_q <= 1'b0;
                    end
                end

                ST_SHIFT_LO: begin
                    if (phase_end) begin
                        // The tail bit is sampled before the rising edge
                        // pushes it out of the chain.
                        state     <= ST_SHIFT_HI;
                        phase_cnt <= '0;
                        prog_clk  <= 1'b1;
                        tail_crc  <= crc16_step(tail_crc, ccff_tail);
                    end else begin
                        phase_cnt <= phase_cnt + PH_ONE;
                    end
                end

                ST_SHIFT_HI: begin
                    if (phase_end) begin
                        phase_cnt    <= '0;
                        prog_clk     <= 1'b0;
                        bit_cnt      <= bit_cnt - CNT_ONE;
                        shift_reg    <= {shift_reg[6:0], 1'b0};
                        bits_in_byte <= bits_in_byte - 4'd1;
                        if (last_chain_bit) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (last_byte_bit) begin
                            state        <= ST_WAIT_BYTE;
                            byte_ready_q <= 1'b1;
                        end else begin
                            // shift_reg[6] becomes the new MSB on this edge
                            state     <= ST_SHIFT_LO;
                            ccff_head <= shift_reg[6];
                        end
                    end else begin
                        phase_cnt <= phase_cnt + PH_ONE;
                    end
                end

                default: begin
                    state        <= ST_IDLE;
                    phase_cnt    <= '0;
                    byte_ready_q <= 1'b0;
                    prog_clk     <= 1'b0;
                    cfg_set      <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_bitstream_loader
//
// Two loader instances share clk/rst_n:
//   dut_a  CHAIN_LEN=16, DIV=1, attached to a 16-bit fabric shift-register
//          model whose last bit feeds ccff_tail
//   dut_b  CHAIN_LEN=12, DIV=2, used for the partial final byte and
//          half-period width checks
// Expected values are hand-computed constants. In particular 0x0EC9 is the
// CRC-16/CCITT-FALSE of the bytes 0x12, 0x34 (fabric preload 0x1234 read
// back MSB-first).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ccff_bitstream_loader;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // ---------------- dut_a ----------------
    logic        start_a, abort_a, ccff_tail_a;
    logic        prog_clk_a, ccff_head_a, cfg_set_a, busy_a, done_a, aborted_a;
    logic [15:0] tail_crc_a;
    ccff_bitstream_loader_if if_a ();

    ccff_bitstream_loader #(.CHAIN_LEN(16), .DIV(1)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_a),
        .abort     (abort_a),
        .byte_if   (if_a),
        .ccff_tail (ccff_tail_a),
        .prog_clk  (prog_clk_a),
        .ccff_head (ccff_head_a),
        .cfg_set   (cfg_set_a),
        .busy      (busy_a),
        .done      (done_a),
        .aborted   (aborted_a),
        .tail_crc  (tail_crc_a)
    );

    // ---------------- dut_b ----------------
    logic        start_b, abort_b, ccff_tail_b;
    logic        prog_clk_b, ccff_head_b, cfg_set_b, busy_b, done_b, aborted_b;
    logic [15:0] tail_crc_b;
    ccff_bitstream_loader_if if_b ();

    ccff_bitstream_loader #(.CHAIN_LEN(12), .DIV(2)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_b),
        .abort     (abort_b),
        .byte_if   (if_b),
        .ccff_tail (ccff_tail_b),
        .prog_clk  (prog_clk_b),
        .ccff_head (ccff_head_b),
        .cfg_set   (cfg_set_b),
        .busy      (busy_b),
        .done      (done_b),
        .aborted   (aborted_b),
        .tail_crc  (tail_crc_b)
    );

    // Fabric chain model for dut_a: shifts on prog_clk rising edge.
    logic [15:0] fab;
    logic [15:0] fab_seed;
    logic        fab_load;
    int          pulse_cnt_a;
    logic [31:0] head_log_a;

    always @(posedge prog_clk_a or posedge fab_load) begin
        if (fab_load) fab <= fab_seed;
        else          fab <= {fab[14:0], ccff_head_a};
    end

    always @(posedge prog_clk_a) begin
        pulse_cnt_a <= pulse_cnt_a + 1;
        head_log_a  <= {head_log_a[30:0], ccff_head_a};
    end

    assign ccff_tail_a = fab[15];

    task automatic preload_fabric(input logic [15:0] seed);
        fab_seed = seed;
        fab_load = 1'b1;
        #1 fab_load = 1'b0;
    endtask

    // Starts dut_a and feeds two bytes, optionally withholding byte_valid
    // for 'stall' cycles once the loader asks for the second byte.
    task automatic run_load_a(input  logic [7:0] b0,
                              input  logic [7:0] b1,
                              input  int         stall,
                              output int         ready_lat,
                              output int         cfg_cycles,
                              output int         ready_after,
                              output int         stall_bad,
                              output bit         timed_out);
        int n;
        int idx;
        int stall_left;
        bit stalling;
        bit accept;
        n = 0; idx = 0; stall_left = stall; stalling = 0;
        ready_lat = 0; cfg_cycles = 0; ready_after = 0; stall_bad = 0;
        if_a.byte_valid = 1'b0;
        if_a.byte_data  = b0;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        n = 1;
        while (!done_a && n < 600) begin
            if (cfg_set_a) cfg_cycles++;
            if (if_a.byte_ready && ready_lat == 0) ready_lat = n;
            if (idx >= 2 && if_a.byte_ready) ready_after++;
            if (idx == 1 && if_a.byte_ready) stalling = 1;
            if_a.byte_valid = (idx < 2) && !(idx == 1 && stall_left > 0);
            if_a.byte_data  = (idx == 0) ? b0 : b1;
            accept = if_a.byte_valid && if_a.byte_ready;
            if (stalling && stall_left > 0) begin
                if (prog_clk_a || !if_a.byte_ready) stall_bad++;
                stall_left--;
            end
            @(posedge clk); #1;
            n++;
            if (accept) idx++;
        end
        if_a.byte_valid = 1'b0;
        timed_out = !done_a;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        total++; if (prog_clk_a !== 1'b0) begin bad++; $display("[TB] FAIL rst_prog_clk: got %b want 0", prog_clk_a); end
        total++; if (ccff_head_a !== 1'b0) begin bad++; $display("[TB] FAIL rst_ccff_head: got %b want 0", ccff_head_a); end
        total++; if (cfg_set_a !== 1'b0) begin bad++; $display("[TB] FAIL rst_cfg_set: got %b want 0", cfg_set_a); end
        total++; if (if_a.byte_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_byte_ready: got %b want 0", if_a.byte_ready); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b want 0", busy_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("[TB] FAIL rst_done: got %b want 0", done_a); end
        total++; if (aborted_a !== 1'b0) begin bad++; $display("[TB] FAIL rst_aborted: got %b want 0", aborted_a); end
        total++; if (tail_crc_a !== 16'hFFFF) begin bad++; $display("[TB] FAIL rst_tail_crc: got %h want ffff", tail_crc_a); end
        total++; if (prog_clk_b !== 1'b0) begin bad++; $display("[TB] FAIL rst_b_prog_clk: got %b want 0", prog_clk_b); end
        total++; if (busy_b !== 1'b0) begin bad++; $display("[TB] FAIL rst_b_busy: got %b want 0", busy_b); end
    endtask

    task automatic test_basic_load();
        int lat, cfgc, rdy_after, sbad, base;
        bit to;
        $display("[TB] test_basic_load");
        preload_fabric(16'h1234);
        base = pulse_cnt_a;
        run_load_a(8'hA5, 8'h3C, 0, lat, cfgc, rdy_after, sbad, to);
        total++; if (to) begin bad++; $display("[TB] FAIL basic_timeout: done=%b want 1", done_a); end
        total++; if (lat != 5) begin bad++; $display("[TB] FAIL start_to_ready: got %0d want 5", lat); end
        total++; if (cfgc != 4) begin bad++; $display("[TB] FAIL cfg_set_cycles: got %0d want 4", cfgc); end
        total++; if (pulse_cnt_a - base != 16) begin bad++; $display("[TB] FAIL basic_pulses: got %0d want 16", pulse_cnt_a - base); end
        total++; if (head_log_a[15:0] !== 16'hA53C) begin bad++; $display("[TB] FAIL basic_head_bits: got %h want a53c", head_log_a[15:0]); end
        total++; if (rdy_after != 0) begin bad++; $display("[TB] FAIL basic_ready_after_last: got %0d want 0", rdy_after); end
        total++; if (busy_a !== 1'b0 || prog_clk_a !== 1'b0) begin bad++; $display("[TB] FAIL basic_done_outputs: busy=%b prog_clk=%b want 0 0", busy_a, prog_clk_a); end
        total++; if (fab !== 16'hA53C) begin bad++; $display("[TB] FAIL fabric_contents: got %h want a53c", fab); end
        total++; if (tail_crc_a !== 16'h0EC9) begin bad++; $display("[TB] FAIL tail_crc: got %h want 0ec9", tail_crc_a); end
    endtask

    task automatic test_partial_byte();
        int n, idx, rises, hi, lo, hi_min, hi_max, lo_min, rise_n, rdy_after;
        bit prev, accept;
        logic [11:0] log_b;
        $display("[TB] test_partial_byte");
        n = 0; idx = 0; rises = 0; hi = 0; lo = 0; hi_min = 99; hi_max = 0; lo_min = 99;
        rise_n = 0; rdy_after = 0; prev = 0; log_b = '0;
        if_b.byte_valid = 1'b0;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        n = 1;
        while (!done_b && n < 600) begin
            if (prog_clk_b && !prev) begin
                rises++;
                log_b = {log_b[10:0], ccff_head_b};
                rise_n = n;
                if (rises > 1 && lo < lo_min) lo_min = lo;
                lo = 0;
            end
            if (prog_clk_b) hi++;
            else begin
                if (prev) begin
                    if (hi < hi_min) hi_min = hi;
                    if (hi > hi_max) hi_max = hi;
                    hi = 0;
                end
                if (rises > 0) lo++;
            end
            prev = prog_clk_b;
            if (idx >= 2 && if_b.byte_ready) rdy_after++;
            if_b.byte_valid = (idx < 2);
            if_b.byte_data  = (idx == 0) ? 8'hFF : 8'hF0;
            accept = if_b.byte_valid && if_b.byte_ready;
            @(posedge clk); #1;
            n++;
            if (accept) idx++;
        end
        if_b.byte_valid = 1'b0;
        if (prev && !prog_clk_b) begin
            if (hi < hi_min) hi_min = hi;
            if (hi > hi_max) hi_max = hi;
        end
        total++; if (!done_b) begin bad++; $display("[TB] FAIL partial_timeout: done=%b want 1", done_b); end
        total++; if (rises != 12) begin bad++; $display("[TB] FAIL partial_pulses: got %0d want 12", rises); end
        total++; if (log_b !== 12'hFFF) begin bad++; $display("[TB] FAIL partial_head_bits: got %h want fff", log_b); end
        total++; if (hi_min != 2 || hi_max != 2) begin bad++; $display("[TB] FAIL partial_high_width: got %0d..%0d want 2..2", hi_min, hi_max); end
        total++; if (lo_min != 2) begin bad++; $display("[TB] FAIL partial_low_width: got %0d want 2", lo_min); end
        total++; if (n - rise_n != 2) begin bad++; $display("[TB] FAIL partial_done_latency: got %0d want 2", n - rise_n); end
        total++; if (rdy_after != 0) begin bad++; $display("[TB] FAIL partial_ready_after_last: got %0d want 0", rdy_after); end
        total++; if (busy_b !== 1'b0) begin bad++; $display("[TB] FAIL partial_busy: got %b want 0", busy_b); end
    endtask

    task automatic test_byte_stall();
        int lat, cfgc, rdy_after, sbad, base;
        bit to;
        $display("[TB] test_byte_stall");
        base = pulse_cnt_a;
        run_load_a(8'h5A, 8'hC3, 20, lat, cfgc, rdy_after, sbad, to);
        total++; if (to) begin bad++; $display("[TB] FAIL stall_timeout: done=%b want 1", done_a); end
        total++; if (sbad != 0) begin bad++; $display("[TB] FAIL stall_idle_chain: got %0d bad cycles want 0", sbad); end
        total++; if (pulse_cnt_a - base != 16) begin bad++; $display("[TB] FAIL stall_pulses: got %0d want 16", pulse_cnt_a - base); end
        total++; if (head_log_a[15:0] !== 16'h5AC3) begin bad++; $display("[TB] FAIL stall_head_bits: got %h want 5ac3", head_log_a[15:0]); end
        total++; if (fab !== 16'h5AC3) begin bad++; $display("[TB] FAIL stall_fabric: got %h want 5ac3", fab); end
    endtask

    task automatic test_abort();
        int n, base, lat, cfgc, rdy_after, sbad;
        bit to;
        logic [15:0] crc_snap;
        $display("[TB] test_abort");
        base = pulse_cnt_a;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        if_a.byte_data  = 8'hC3;
        if_a.byte_valid = 1'b1;
        n = 0;
        while (!(pulse_cnt_a - base == 5 && prog_clk_a) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        total++; if (n >= 200) begin bad++; $display("[TB] FAIL abort_reach_bit5: pulses=%0d want 5", pulse_cnt_a - base); end
        crc_snap = tail_crc_a;
        abort_a = 1'b1;
        if_a.byte_valid = 1'b0;
        @(posedge clk); #1;
        abort_a = 1'b0;
        total++; if (prog_clk_a !== 1'b0) begin bad++; $display("[TB] FAIL abort_prog_clk: got %b want 0", prog_clk_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got %b want 0", busy_a); end
        total++; if (aborted_a !== 1'b1) begin bad++; $display("[TB] FAIL abort_flag: got %b want 1", aborted_a); end
        total++; if (if_a.byte_ready !== 1'b0 || cfg_set_a !== 1'b0 || done_a !== 1'b0) begin bad++; $display("[TB] FAIL abort_outputs: ready=%b cfg_set=%b done=%b want 0 0 0", if_a.byte_ready, cfg_set_a, done_a); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (tail_crc_a !== crc_snap) begin bad++; $display("[TB] FAIL abort_crc_frozen: got %h want %h", tail_crc_a, crc_snap); end
        total++; if (aborted_a !== 1'b1) begin bad++; $display("[TB] FAIL abort_sticky: got %b want 1", aborted_a); end
        total++; if (pulse_cnt_a - base != 5) begin bad++; $display("[TB] FAIL abort_extra_pulses: got %0d want 5", pulse_cnt_a - base); end
        base = pulse_cnt_a;
        run_load_a(8'h96, 8'h69, 0, lat, cfgc, rdy_after, sbad, to);
        total++; if (to) begin bad++; $display("[TB] FAIL reload_timeout: done=%b want 1", done_a); end
        total++; if (aborted_a !== 1'b0) begin bad++; $display("[TB] FAIL reload_aborted_clear: got %b want 0", aborted_a); end
        total++; if (pulse_cnt_a - base != 16) begin bad++; $display("[TB] FAIL reload_pulses: got %0d want 16", pulse_cnt_a - base); end
        total++; if (head_log_a[15:0] !== 16'h9669) begin bad++; $display("[TB] FAIL reload_head_bits: got %h want 9669", head_log_a[15:0]); end
    endtask

    task automatic test_reset_mid_load();
        int n, base, lat, cfgc, rdy_after, sbad;
        bit to;
        $display("[TB] test_reset_mid_load");
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        if_a.byte_data  = 8'hFF;
        if_a.byte_valid = 1'b1;
        n = 0;
        while (!prog_clk_a && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        total++; if (n >= 200) begin bad++; $display("[TB] FAIL rstmid_reach_shift: prog_clk=%b want 1", prog_clk_a); end
        rst_n = 1'b0;
        #1;
        total++; if (prog_clk_a !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_async_prog_clk: got %b want 0", prog_clk_a); end
        total++; if (busy_a !== 1'b0 || done_a !== 1'b0 || aborted_a !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_flags: busy=%b done=%b aborted=%b want 0 0 0", busy_a, done_a, aborted_a); end
        total++; if (ccff_head_a !== 1'b0 || cfg_set_a !== 1'b0 || if_a.byte_ready !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_outputs: head=%b cfg_set=%b ready=%b want 0 0 0", ccff_head_a, cfg_set_a, if_a.byte_ready); end
        total++; if (tail_crc_a !== 16'hFFFF) begin bad++; $display("[TB] FAIL rstmid_tail_crc: got %h want ffff", tail_crc_a); end
        if_a.byte_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        base = pulse_cnt_a;
        run_load_a(8'h3C, 8'hA5, 0, lat, cfgc, rdy_after, sbad, to);
        total++; if (to) begin bad++; $display("[TB] FAIL rstmid_reload_timeout: done=%b want 1", done_a); end
        total++; if (pulse_cnt_a - base != 16) begin bad++; $display("[TB] FAIL rstmid_reload_pulses: got %0d want 16", pulse_cnt_a - base); end
        total++; if (head_log_a[15:0] !== 16'h3CA5) begin bad++; $display("[TB] FAIL rstmid_reload_head_bits: got %h want 3ca5", head_log_a[15:0]); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        start_a = 1'b0; abort_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0; ccff_tail_b = 1'b0;
        if_a.byte_data = 8'h00; if_a.byte_valid = 1'b0;
        if_b.byte_data = 8'h00; if_b.byte_valid = 1'b0;
        fab_load = 1'b0;
        fab_seed = 16'h0000;
        preload_fabric(16'h1234);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        test_reset();
        test_basic_load();
        test_partial_byte();
        test_byte_stall();
        test_abort();
        test_reset_mid_load();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
